demux_1to4_stream: RTL

Routes one input stream to one of four output channels, the inverse of the 4-to-1 mux. Selection uses a 2-bit select {s1,s0}. Each output channel has a one-entry registered holding stage with a valid/ready handshake, so the four consumers can stall independently. Sits after a shared producer that feeds four downstream units; a 16-bit transfer counter is provided for debug.

---
 rtl/demux_1to4_stream.sv | 76 +++++++
 1 files changed

// File: rtl/demux_1to4_stream.sv
// 1-to-4 stream demultiplexer: {s1,s0} routes each accepted input word into a
// one-entry registered holding stage per channel, each with its own valid/ready.
module demux_1to4_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [15:0]      xfer_count
);

  logic [1:0]       sel;
  logic             accept;
  logic [3:0]       valid_q, valid_d;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [15:0]      count_q, count_d;

  assign sel      = {s1, s0};
  // Ready looks only at the selected slot, so a stalled channel never blocks others.
  assign in_ready = !rst && (!valid_q[sel] || out_ready[sel]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (valid_q[k] && out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
      // Load after drain so a same-cycle drain+load keeps the slot valid.
      if (accept && (sel == 2'(k))) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end
    end
    if (accept) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int unsigned k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out0_data  = data_q[0];
  assign out1_data  = data_q[1];
  assign out2_data  = data_q[2];
  assign out3_data  = data_q[3];
  assign out_valid  = valid_q;
  assign xfer_count = count_q;

endmodule
